// File: rtl/phase_reader.sv
// rtl/phase_reader.sv - ring-oscillator phase reader: synchronize, count XOR mismatches over a window, decide spin
module phase_reader #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] window_len,
    input  logic             osc_a,
    input  logic             osc_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] mismatch_count,
    output logic             spin
);

    typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, REPORT} state_t;

    localparam logic [WIDTH-1:0] SETTLE_LAST = WIDTH'(SYNC_STAGES - 1);

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_a_q, sync_a_d;
    logic [SYNC_STAGES-1:0] sync_b_q, sync_b_d;
    logic [WIDTH-1:0]       timer_q, timer_d;
    logic [WIDTH-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]       len_q, len_d;
    logic [WIDTH-1:0]       mismatch_q, mismatch_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   spin_q, spin_d;
    logic                   diff;

    assign diff = sync_a_q[SYNC_STAGES-1] ^ sync_b_q[SYNC_STAGES-1];

    always_comb begin
        state_d    = state_q;
        sync_a_d   = {sync_a_q[SYNC_STAGES-2:0], osc_a};
        sync_b_d   = {sync_b_q[SYNC_STAGES-2:0], osc_b};
        timer_d    = timer_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        mismatch_d = mismatch_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        spin_d     = spin_q;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    len_d   = window_len;
                    cnt_d   = '0;
                    timer_d = '0;
                    busy_d  = 1'b1;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                // Flush the synchronizers so the first sample belongs to this measurement
                if (timer_q == SETTLE_LAST) begin
                    timer_d = '0;
                    state_d = (len_q == '0) ? REPORT : MEASURE;
                end else begin
                    timer_d = timer_q + WIDTH'(1);
                end
            end
            MEASURE: begin
                cnt_d = cnt_q + WIDTH'(diff);
                if (timer_q == len_q - WIDTH'(1)) begin
                    state_d = REPORT;
                end else begin
                    timer_d = timer_q + WIDTH'(1);
                end
            end
            REPORT: begin
                done_d     = 1'b1;
                mismatch_d = cnt_q;
                // One extra bit so 2*count cannot overflow; a tie stays in phase
                spin_d     = ({cnt_q, 1'b0} > {1'b0, len_q});
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sync_a_q   <= '0;
            sync_b_q   <= '0;
            timer_q    <= '0;
            cnt_q      <= '0;
            len_q      <= '0;
            mismatch_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            spin_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_a_q   <= sync_a_d;
            sync_b_q   <= sync_b_d;
            timer_q    <= timer_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            mismatch_q <= mismatch_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            spin_q     <= spin_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign mismatch_count = mismatch_q;
    assign spin           = spin_q;

endmodule

// File: tb/tb_phase_reader.sv
// tb/tb_phase_reader.sv - self-checking bench for phase_reader against a per-edge sample-history model
module tb_phase_reader;

    localparam int WIDTH = 16;
    localparam int S     = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] window_len;
    logic             osc_a;
    logic             osc_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] mismatch_count;
    logic             spin;

    phase_reader #(.WIDTH(WIDTH), .SYNC_STAGES(S)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .window_len     (window_len),
        .osc_a          (osc_a),
        .osc_b          (osc_b),
        .busy           (busy),
        .done           (done),
        .mismatch_count (mismatch_count),
        .spin           (spin)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int edge_n   = 0;
    int mode     = 0;
    int sq_cnt   = 0;
    bit sq_val   = 1'b0;
    bit flip     = 1'b0;
    bit ra [0:16383];
    bit rb [0:16383];

    // Raw oscillator value seen at every rising edge, indexed by edge number
    always @(posedge clk) begin
        if (edge_n < 16384) begin
            ra[edge_n] = osc_a;
            rb[edge_n] = osc_b;
        end
        edge_n++;
    end

    always @(negedge clk) begin
        if (sq_cnt == 4) begin
            sq_cnt = 0;
            sq_val = ~sq_val;
        end else begin
            sq_cnt++;
        end
        case (mode)
            0: begin osc_a = sq_val; osc_b = sq_val;  end
            1: begin osc_a = sq_val; osc_b = ~sq_val; end
            2: begin osc_a = 1'b1;   osc_b = 1'(edge_n) ^ flip; end
            default: begin osc_a = 1'($urandom); osc_b = 1'($urandom); end
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_mode(input int m);
        @(posedge clk);
        #1 mode = m;
    endtask

    // One measurement: the k+1..k+len edges after the accepting edge k are the sampled window
    task automatic run(input int len, input bit disturb);
        int  k;
        int  lat;
        int  exp_cnt;
        bit  seen;
        @(negedge clk);
        start      = 1'b1;
        window_len = WIDTH'(len);
        @(negedge clk);
        k          = edge_n - 1;
        start      = 1'b0;
        window_len = WIDTH'($urandom);
        check("busy_after_accept", busy, 1);
        seen = 1'b0;
        lat  = 0;
        for (int c = 0; c < len + S + 20; c++) begin
            if (done) begin
                seen = 1'b1;
                lat  = edge_n - 1 - k;
                break;
            end
            if (disturb && c == 20) begin
                start      = 1'b1;
                window_len = WIDTH'(3);
            end
            if (disturb && c == 21) start = 1'b0;
            @(negedge clk);
        end
        exp_cnt = 0;
        for (int i = 1; i <= len; i++) exp_cnt += int'(ra[k+i] ^ rb[k+i]);
        check("done_seen", 32'(seen), 1);
        check("latency", lat, len + S + 1);
        check("busy_in_done", busy, 1);
        check("count_model", mismatch_count, exp_cnt);
        check("spin_model", spin, 32'(2 * exp_cnt > len));
    endtask

    initial begin
        bit seen_done;
        logic [WIDTH-1:0] held;
        rst        = 1'b1;
        start      = 1'b0;
        window_len = '0;
        repeat (4) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_count", mismatch_count, 0);
        check("rst_spin", spin, 0);
        rst = 1'b0;

        set_mode(0);
        run(100, 0);
        check("inphase_count", mismatch_count, 0);
        check("inphase_spin", spin, 0);

        set_mode(1);
        run(100, 0);
        check("antiphase_count", mismatch_count, 100);
        check("antiphase_spin", spin, 1);

        set_mode(2);
        run(10, 0);
        check("tie_count", mismatch_count, 5);
        check("tie_spin", spin, 0);
        @(posedge clk);
        #1 flip = 1'((edge_n + 1) % 2);
        run(11, 0);
        check("odd_count", mismatch_count, 6);
        check("odd_spin", spin, 1);

        set_mode(3);
        run(0, 0);
        check("zero_count", mismatch_count, 0);
        check("zero_spin", spin, 0);

        held = mismatch_count;
        @(negedge clk);
        check("done_one_cycle", done, 0);
        repeat (4) @(negedge clk);
        check("idle_busy", busy, 0);
        check("hold_count", mismatch_count, held);

        run(100, 1);
        run(7, 0);
        run(9, 0);
        for (int r = 0; r < 6; r++) run($urandom_range(0, 40), 0);

        @(negedge clk);
        start      = 1'b1;
        window_len = WIDTH'(50);
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_count", mismatch_count, 0);
        check("abort_spin", spin, 0);
        seen_done = 1'b0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (done || busy) seen_done = 1'b1;
        end
        check("abort_no_done", 32'(seen_done), 0);

        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        check("rst_over_start", busy, 0);
        rst   = 1'b0;
        start = 1'b0;
        run(12, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/phase_reader.md
PHASE_READER -- requirements
Module: phase_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 16, the width of the window length and of the mismatch counter.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, the flip-flop depth of each oscillator input synchronizer (minimum 2).
REQ-003 SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port rst, input, 1, the reset; synchronous, active-high.
REQ-005 SHALL have port start, input, 1, a request to begin one measurement.
REQ-006 SHALL have port window_len, input, WIDTH, the number of measurement samples; captured when start is accepted.
REQ-007 SHALL have port osc_a, input, 1, a raw, asynchronous ring-oscillator tap.
REQ-008 SHALL have port osc_b, input, 1, a raw, asynchronous ring-oscillator tap, compared against osc_a.
REQ-009 SHALL have port busy, output, 1, high while a measurement is in progress.
REQ-010 SHALL have port done, output, 1, a one-cycle pulse marking valid results.
REQ-011 SHALL have port mismatch_count, output, WIDTH, the number of sampled cycles in which the synchronized osc_a and osc_b differed.
REQ-012 SHALL have port spin, output, 1, the phase decision: 0 means in phase, 1 means anti-phase.

Function
REQ-013 SHALL pass osc_a and osc_b each through its own SYNC_STAGES-deep flip-flop chain; no logic SHALL use the raw inputs.
REQ-014 SHALL implement a state machine with states IDLE, SETTLE, MEASURE and REPORT.
REQ-015 SHALL, in IDLE with start=1 at edge k, capture window_len, clear the internal counter, and enter SETTLE at edge k.
REQ-016 SHALL remain in SETTLE for exactly SYNC_STAGES cycles, counting nothing, then enter MEASURE.
REQ-017 SHALL, in MEASURE, sample the synchronized XOR once per cycle for exactly the captured window_len cycles, incrementing the counter when the XOR is 1, then enter REPORT.
REQ-018 SHALL, with a captured window_len of 0, go from SETTLE directly to REPORT with a count of 0.
REQ-019 SHALL hold REPORT for one cycle with done=1, then return to IDLE.
REQ-020 SHALL, in REPORT, drive mismatch_count with the final count and spin with 1 if and only if 2*count > window_len; the comparison SHALL use WIDTH+1 bits.
REQ-021 SHALL hold mismatch_count and spin stable from REPORT until the next start is accepted.
REQ-022 SHALL drive busy=1 in SETTLE, MEASURE and REPORT, and busy=0 in IDLE.
REQ-023 SHALL give a total latency from the accepting edge to the done cycle of SYNC_STAGES + window_len + 1 cycles.
REQ-024 SHALL ignore start while busy=1; there SHALL be no queuing.
REQ-025 SHALL ignore window_len changes after capture.
REQ-026 SHALL accept a start asserted in the cycle immediately after done, with no dead cycle.
REQ-027 SHALL never wrap the counter; count ≤ window_len ≤ 2^WIDTH-1 by construction.
REQ-028 SHALL make spin exactly 0 when 2*count equals window_len (tie goes to in phase).

Reset
REQ-029 SHALL, with rst=1 at an edge, force IDLE and set busy=0, done=0, mismatch_count=0, spin=0, the counter to 0 and all synchronizer flops to 0.
REQ-030 SHALL abort any measurement in progress on rst, with no done pulse, and never report partial results.
REQ-031 SHALL give rst priority over start in the same cycle.

Verification
REQ-032 SHALL pass this scenario: SYNC_STAGES=2, osc_a=osc_b tied to the same 1 MHz square wave, window_len=100 -> done exactly 103 cycles after accept, mismatch_count=0, spin=0.
REQ-033 SHALL pass this scenario: osc_b = ~osc_a, window_len=100 -> mismatch_count=100, spin=1.
REQ-034 SHALL pass this scenario: osc_a=1, osc_b toggling every cycle, window_len=10 -> mismatch_count=5, spin=0 (tie); window_len=11, with the first sampled cycle a mismatch -> mismatch_count=6, spin=1.
REQ-035 SHALL pass this scenario: window_len=0 -> done 3 cycles after accept, mismatch_count=0, spin=0.
REQ-036 SHALL pass this scenario: start pulsed again mid-MEASURE, and window_len changed mid-MEASURE -> both ignored; the result matches the originally captured length.
REQ-037 SHALL pass this scenario: rst asserted mid-MEASURE -> the next cycle has busy=0, all outputs 0, and no done pulse; a fresh start then completes normally.
